// File: rtl/serv_rd_deser_if.sv
// Bundle of serial-in / parallel-out signals for serv_rd_deser.
// The slave modport is the deserializer; the master modport is the source/consumer pair.
interface serv_rd_deser_if #(
  parameter int WIDTH = 32
);
  logic             i_en;
  logic             i_d;
  logic             i_cnt_done;
  logic             i_ready;
  logic             o_valid;
  logic [WIDTH-1:0] o_data;
  logic             o_busy;
  logic             o_len_err;
  logic             o_ovf;

  modport slave (
    input  i_en, i_d, i_cnt_done, i_ready,
    output o_valid, o_data, o_busy, o_len_err, o_ovf
  );

  modport master (
    output i_en, i_d, i_cnt_done, i_ready,
    input  o_valid, o_data, o_busy, o_len_err, o_ovf
  );
endinterface

// File: rtl/serv_rd_deser.sv
// Collects an LSB-first serial result stream into WIDTH-bit words and offers them on valid/ready.
// Define SERV_RD_DESER_BUF2_EN for a 2-entry output FIFO instead of a single holding register.
module serv_rd_deser #(
  parameter int WIDTH = 32
) (
  input  logic            clk,
  input  logic            i_rst,
  serv_rd_deser_if.slave  io_bus
);
  // Handshake: a word transfers on every rising edge where o_valid & i_ready; o_data is held
  // stable while o_valid & !i_ready. The serial side (i_en) is never stalled.

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {S_IDLE = 1'b0, S_SHIFT = 1'b1} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_nxt;
  logic [WIDTH-1:0] r_sreg;
  logic [WIDTH-1:0] w_word;
  logic             w_push;
  logic             w_len_err;
  logic             w_pop;
  logic             r_len_err;
  logic             r_ovf;

  assign w_word = {io_bus.i_d, r_sreg[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_sreg    <= '0;
      r_len_err <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_len_err <= w_len_err;
      if (io_bus.i_en) r_sreg <= w_word;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (io_bus.i_en && !io_bus.i_cnt_done) begin
          w_state_nxt = S_SHIFT;
          w_cnt_nxt   = CW'(1);
        end
      end
      S_SHIFT: begin
        if (io_bus.i_en) begin
          // Done or an overlong word both end the word; the counter never wraps.
          if (io_bus.i_cnt_done || (r_cnt == LAST)) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    w_push    = 1'b0;
    w_len_err = 1'b0;
    if (io_bus.i_en) begin
      case (r_state)
        S_IDLE:  w_len_err = io_bus.i_cnt_done;
        S_SHIFT: begin
          if (io_bus.i_cnt_done) begin
            w_push    = (r_cnt == LAST);
            w_len_err = (r_cnt != LAST);
          end else begin
            w_len_err = (r_cnt == LAST);
          end
        end
        default: w_len_err = 1'b0;
      endcase
    end
  end

`ifdef SERV_RD_DESER_BUF2_EN
  logic [WIDTH-1:0] r_mem [2];
  logic             r_rp;
  logic             r_wp;
  logic [1:0]       r_count;
  logic             w_wr;

  assign w_pop = (r_count != 2'd0) && io_bus.i_ready;
  assign w_wr  = w_push && ((r_count != 2'd2) || w_pop);

  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_rp     <= 1'b0;
      r_wp     <= 1'b0;
      r_count  <= 2'd0;
      r_ovf    <= 1'b0;
    end else begin
      r_ovf <= w_push && !w_wr;
      if (w_wr) begin
        r_mem[r_wp] <= w_word;
        r_wp        <= ~r_wp;
      end
      if (w_pop) r_rp <= ~r_rp;
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign io_bus.o_valid = (r_count != 2'd0);
  assign io_bus.o_data  = r_mem[r_rp];
`else
  logic             r_valid;
  logic [WIDTH-1:0] r_data;

  assign w_pop = r_valid && io_bus.i_ready;

  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_ovf <= 1'b0;
      if (w_push) begin
        // A full register with no pop keeps the old word; the new one is lost.
        if (!r_valid || w_pop) begin
          r_data  <= w_word;
          r_valid <= 1'b1;
        end else begin
          r_ovf <= 1'b1;
        end
      end else if (w_pop) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign io_bus.o_valid = r_valid;
  assign io_bus.o_data  = r_data;
`endif

  assign io_bus.o_busy    = (r_state == S_SHIFT);
  assign io_bus.o_len_err = r_len_err;
  assign io_bus.o_ovf     = r_ovf;
endmodule
